gcd_controller: RTL and testbench

Control FSM for the GCD subtract-and-swap datapath. It accepts a start request and two operands over a valid/ready handshake, and drives the datapath's load and select strobes (`ldA`, `ldB`, `selA_sub`, `selB_sub`) from its `gt`/`lt`/`eq` flags until the operands are equal. It then pulses `done`, and the datapath's A output holds the result. It sits directly upstream of the datapath and shares the operand bus (`data_in`) with it.

---
 rtl/gcd_controller_if.sv | 46 ++++
 rtl/gcd_controller.sv | 128 ++++++++++++
 tb/tb_gcd_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle between the GCD
// controller (slave side) and its operand source/datapath.
interface gcd_controller_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             ldA;
    logic             ldB;
    logic             selA_sub;
    logic             selB_sub;
    logic             busy;
    logic             done;
    logic             err;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_count;
`endif

    modport slave (
`ifdef GCD_ITER_COUNT_EN
        output iter_count,
`endif
        input  start, in_valid, a_val, b_val,
        input  gt, lt, eq,
        output in_ready, ldA, ldB,
        output selA_sub, selB_sub,
        output busy, done, err
    );

    modport master (
`ifdef GCD_ITER_COUNT_EN
        input  iter_count,
`endif
        output start, in_valid, a_val, b_val,
        output gt, lt, eq,
        input  in_ready, ldA, ldB,
        input  selA_sub, selB_sub,
        input  busy, done, err
    );
endinterface

// File: rtl/gcd_controller.sv
// GCD subtract-and-swap control FSM.
// Ports: clk, rst_n (sync, active-low), bus (gcd_controller_if.slave):
//   start/in_valid/in_ready operand handshake, a_val/b_val/gt/lt/eq
//   datapath status, ldA/ldB/selA_sub/selB_sub strobes, busy/done/err.
// Optional macro GCD_ITER_COUNT_EN adds bus.iter_count (subtraction count).
module gcd_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_controller_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_CALC   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_err;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_zero;
    logic             w_in_ready;
    logic             w_ldA;
    logic             w_ldB;
    logic             w_selA;
    logic             w_selB;
    logic             w_done;

    assign w_a    = bus.a_val;
    assign w_b    = bus.b_val;
    assign w_zero = (w_a == '0) || (w_b == '0);

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_ldA      = 1'b0;
        w_ldB      = 1'b0;
        w_selA     = 1'b0;
        w_selB     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_ldA  = 1'b1;
                    w_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_ldB  = 1'b1;
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_zero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                // No flag high is illegal: idle in CALC, no strobes.
                if (bus.eq) begin
                    w_next = S_DONE;
                end else if (bus.gt) begin
                    w_ldA  = 1'b1;
                    w_selA = 1'b1;
                end else if (bus.lt) begin
                    w_ldB  = 1'b1;
                    w_selB = 1'b1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start)
                r_err <= 1'b0;
            else if (r_state == S_CHECK && w_zero)
                r_err <= 1'b1;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] r_iter;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_iter <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_iter <= '0;
        end else if (r_state == S_CALC &&
                     (w_ldA || w_ldB) &&
                     r_iter != '1) begin
            r_iter <= r_iter + 1'b1;
        end
    end

    assign bus.iter_count = r_iter;
`endif

    assign bus.in_ready = w_in_ready;
    assign bus.ldA      = w_ldA;
    assign bus.ldB      = w_ldB;
    assign bus.selA_sub = w_selA;
    assign bus.selB_sub = w_selB;
    assign bus.done     = w_done;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.err      = r_err;
endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a behavioural
// subtract-and-swap datapath model driving the flags.
module tb_gcd_controller;
    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [15:0] r_A;
    logic [15:0] r_B;
    int          n_cmp;
    int          n_bad;

    gcd_controller_if #(.WIDTH(16)) bus ();

    gcd_controller #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ldA)
            r_A <= bus.selA_sub ? r_A - r_B : data_in;
        if (bus.ldB)
            r_B <= bus.selB_sub ? r_B - r_A : data_in;
    end

    assign bus.a_val = r_A;
    assign bus.b_val = r_B;
    assign bus.gt    = r_A > r_B;
    assign bus.lt    = r_A < r_B;
    assign bus.eq    = r_A == r_B;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
        chk({tag, " err"}, 32'(bus.err), 0);
        chk({tag, " rdy"}, 32'(bus.in_ready), 0);
        chk({tag, " strb"},
            32'({bus.ldA, bus.ldB,
                 bus.selA_sub, bus.selB_sub}), 0);
`ifdef GCD_ITER_COUNT_EN
        chk({tag, " iter"}, 32'(bus.iter_count), 0);
`endif
    endtask

    task automatic run(input string tag,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input int sa,
                       input int sb,
                       input bit poke,
                       input logic [15:0] eres,
                       input bit eerr,
                       input int ecyc,
                       input int nsub);
        int cyc;
        int la;
        int lb;
        int ns;
        int rdy;
        int sta;
        int stb;
        bit got;
        cyc = 0;
        la  = 0;
        lb  = 0;
        ns  = 0;
        rdy = 0;
        sta = sa;
        stb = sb;
        got = 0;
        @(negedge clk);
        chk({tag, " idle"}, 32'(bus.busy), 0);
        bus.start = 1'b1;
        while (cyc < 70000) begin
            @(negedge clk);
            cyc++;
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            if (cyc == 1)
                chk({tag, " errclr"}, 32'(bus.err), 0);
            if (bus.done) begin
                got = 1;
                break;
            end
            if (bus.in_ready) begin
                rdy++;
                if (la == 0 && sta > 0) begin
                    sta--;
                end else if (la != 0 && stb > 0) begin
                    stb--;
                end else begin
                    bus.in_valid = 1'b1;
                    data_in = (la == 0) ? a : b;
                end
            end
            if (poke && (cyc % 997) == 500)
                bus.start = 1'b1;
            #1;
            if (bus.ldA && !bus.selA_sub) la++;
            if (bus.ldB && !bus.selB_sub) lb++;
            if ((bus.ldA && bus.selA_sub) ||
                (bus.ldB && bus.selB_sub))
                ns++;
        end
        chk({tag, " timeout"}, 32'(got), 1);
        chk({tag, " cycle"}, cyc, ecyc);
        chk({tag, " err"}, 32'(bus.err), 32'(eerr));
        chk({tag, " busy"}, 32'(bus.busy), 1);
        chk({tag, " loads"}, la + lb, 2);
        chk({tag, " rdy"}, rdy, sa + sb + 2);
        chk({tag, " subs"}, ns, nsub);
        if (!eerr)
            chk({tag, " res"}, 32'(r_A), 32'(eres));
`ifdef GCD_ITER_COUNT_EN
        chk({tag, " iter"}, 32'(bus.iter_count), nsub);
`endif
        @(negedge clk);
        chk({tag, " post done"}, 32'(bus.done), 0);
        chk({tag, " post busy"}, 32'(bus.busy), 0);
        chk({tag, " post err"}, 32'(bus.err), 32'(eerr));
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        data_in      = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        run("basic", 16'd12, 16'd8, 0, 0, 0,
            16'd4, 0, 7, 2);
        run("equal", 16'd7, 16'd7, 0, 0, 0,
            16'd7, 0, 5, 0);
        run("zeroA", 16'd0, 16'd9, 0, 0, 0,
            16'd0, 1, 4, 0);
        run("zeroB", 16'd9, 16'd0, 0, 0, 0,
            16'd0, 1, 4, 0);
        run("stall", 16'd35, 16'd14, 3, 2, 0,
            16'd7, 0, 13, 3);

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        data_in      = 16'd65535;
        @(negedge clk);
        data_in      = 16'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("midcalc busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("abort");
        rst_n = 1'b1;

        run("after rst", 16'd12, 16'd8, 0, 0, 0,
            16'd4, 0, 7, 2);
        run("long", 16'd65535, 16'd1, 0, 0, 1,
            16'd1, 0, 65539, 65534);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
